// File: rtl/snes_pad_pkg.sv
// Shared state encoding, button layout and frame helpers for the SNES pad poll path.
// Frames are active-low: a 0 bit means the button is held.
package snes_pad_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LATCH  = 3'd1;
    localparam state_t ST_GAP    = 3'd2;
    localparam state_t ST_READ   = 3'd3;
    localparam state_t ST_COMMIT = 3'd4;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    // ID nibble occupies bits 15:12 and reads all-ones on a genuine pad
    localparam int unsigned ID_MSB = 15;
    localparam int unsigned ID_LSB = 12;

    // Buttons that have a Game Boy equivalent (16'h01FD)
    localparam logic [15:0] GB_MASK = 16'((1 << BTN_B) | (1 << BTN_SELECT) | (1 << BTN_START) |
                                          (1 << BTN_UP) | (1 << BTN_DOWN) | (1 << BTN_LEFT) |
                                          (1 << BTN_RIGHT) | (1 << BTN_A));

    function automatic logic frame_valid(input logic [15:0] frame);
        return frame[ID_MSB:ID_LSB] == 4'b1111;
    endfunction

    // A press is a 1 -> 0 transition on a mapped bit
    function automatic logic new_press(input logic [15:0] old_frame, input logic [15:0] new_frame);
        return |(old_frame & ~new_frame & GB_MASK);
    endfunction

endpackage

// File: rtl/snes_phase_timer.sv
// Loadable down-counter; done is high on the final cycle of a phase.
// Loading N-1 on the edge that enters a phase makes the phase last N cycles.
module snes_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/snes_poll_sequencer.sv
// SNES pad poll controller: schedules polls, drives latch/clock, shifts in 16 bits,
// validates the ID nibble and commits the frame atomically, flagging new mapped presses.
module snes_poll_sequencer
    import snes_pad_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = 300,
    parameter int unsigned POLL_CYCLES = 833333
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_req,
    input  logic        controller_data,
    output logic        controller_latch,
    output logic        controller_clock,
    output logic [15:0] buttons,
    output logic        busy,
    output logic        frame_done,
    output logic        pad_error,
    output logic        joypad_irq
);

    localparam int unsigned PW = $clog2(2 * HALF_CYCLES + 1);
    localparam int unsigned TW = $clog2(POLL_CYCLES + 1);
    localparam logic [PW-1:0] LATCH_LOAD = PW'(2 * HALF_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [TW-1:0] timer_q;
    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [3:0]    bit_q, bit_d;
    logic          low_q, low_d;
    logic [15:0]   shift_q;
    logic [15:0]   buttons_q;
    logic          pad_error_q;
    logic          irq_q;

    logic          tick;
    logic          trigger;
    logic          phase_done;
    logic          load;
    logic [PW-1:0] load_value;
    logic          sample;
    logic          enter_commit;

    assign tick    = (timer_q == TIMER_LAST);
    assign trigger = poll_req | (tick & enable);

    snes_phase_timer #(
        .WIDTH (PW)
    ) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .done       (phase_done)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        bit_d        = bit_q;
        low_d        = low_q;
        load         = 1'b0;
        load_value   = HALF_LOAD;
        sample       = 1'b0;
        enter_commit = 1'b0;

        // Triggers during a poll collapse into a single follow-up poll
        if (state_q != ST_IDLE && trigger) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) begin
                    state_d    = ST_LATCH;
                    pending_d  = 1'b0;
                    load       = 1'b1;
                    load_value = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                if (phase_done) begin
                    state_d = ST_GAP;
                    load    = 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    state_d = ST_READ;
                    bit_d   = 4'd0;
                    low_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_READ: begin
                if (phase_done) begin
                    if (low_q) begin
                        sample = 1'b1;
                        low_d  = 1'b0;
                        load   = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        state_d      = ST_COMMIT;
                        enter_commit = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        low_d = 1'b1;
                        load  = 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= 2'b11;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            bit_q       <= 4'd0;
            low_q       <= 1'b0;
            shift_q     <= 16'hFFFF;
            buttons_q   <= 16'hFFFF;
            pad_error_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], controller_data};
            timer_q   <= tick ? '0 : timer_q + TW'(1);
            state_q   <= state_d;
            pending_q <= pending_d;
            bit_q     <= bit_d;
            low_q     <= low_d;
            if (sample) begin
                shift_q[bit_q] <= sync_q[1];
            end
            // Results land on the edge into COMMIT so they are visible with frame_done
            irq_q <= 1'b0;
            if (enter_commit) begin
                pad_error_q <= ~frame_valid(shift_q);
                if (frame_valid(shift_q)) begin
                    buttons_q <= shift_q;
                    irq_q     <= new_press(buttons_q, shift_q);
                end
            end
        end
    end

    assign controller_latch = (state_q == ST_LATCH);
    assign controller_clock = ~((state_q == ST_READ) && low_q);
    assign busy             = (state_q != ST_IDLE);
    assign frame_done       = (state_q == ST_COMMIT);
    assign buttons          = buttons_q;
    assign pad_error        = pad_error_q;
    assign joypad_irq       = irq_q;

endmodule
